// File: rtl/spi_resp_pkg.sv
// -----------------------------------------------------------------------------
// spi_resp_pkg
// Shared definitions for the SPI serial-SRAM responder:
//   - 23LC-style command opcodes (READ, WRITE, WRMR, RDMR)
//   - mode-register field encodings and the mode register reset value
//   - the responder FSM state type
// -----------------------------------------------------------------------------
package spi_resp_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_WRMR  = 8'h01;
    localparam logic [7:0] CMD_RDMR  = 8'h05;

    // Mode register bits [7:6]
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    // Sequential mode out of reset (0x40)
    localparam logic [7:0] MODE_RESET = {MODE_SEQ, 6'b00_0000};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_DATA_WR = 3'd4,
        ST_DATA_RD = 3'd5,
        ST_IGNORE  = 3'd6
    } spi_resp_state_t;

endpackage

// File: rtl/spi_resp_sync.sv
// -----------------------------------------------------------------------------
// spi_resp_sync
// Brings one asynchronous pin into the clk domain through a 2-FF synchronizer
// and produces registered single-cycle rise/fall pulses. Pin-to-pulse latency
// is 3 clk (2 sync stages + 1 detect stage).
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   pin       : asynchronous input pin
//   rise/fall : one-cycle pulses on a synchronized 0->1 / 1->0 transition
// The synchronizer resets to 0 so that a pin already low when reset drops
// (e.g. CS held low) does not produce a spurious falling edge.
// -----------------------------------------------------------------------------
module spi_resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);

    // [0],[1]: synchronizer stages, [2]: previous synchronized value
    logic [2:0] sync_reg;
    logic       rise_reg;
    logic       fall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 3'b000;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], pin};
            rise_reg <= sync_reg[1] & ~sync_reg[2];
            fall_reg <= ~sync_reg[1] & sync_reg[2];
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/spi_sram_responder.sv
// -----------------------------------------------------------------------------
// spi_sram_responder
// SPI mode-0 responder emulating a 23LC-style serial SRAM. SPI pins are
// oversampled on clk. READ (0x03) / WRITE (0x02) take a 16-bit address whose
// low AW bits index an internal byte array; data streams with auto-increment
// and wrap at DEPTH-1 -> 0.
// Parameters:
//   DEPTH : bytes of storage (power of two, 2..65536)
//   AW    : index width, $clog2(DEPTH)
// Ports:
//   clk, rst           : system clock, asynchronous active-high reset
//   spi_cs, spi_sck    : chip select (active low) and SPI clock from master
//   spi_mosi           : master-to-responder data
//   spi_miso           : responder-to-master data (registered)
//   sel                : transaction active (synchronized view)
//   wr_strobe          : one-cycle pulse per committed write byte
//   wr_addr, wr_data   : index and value of the committed byte
// Optional feature: define SPI_RESP_MODE_REG_EN to add the 8-bit mode register
// with WRMR (0x01) / RDMR (0x05) and byte mode. Without it, 0x01/0x05 are
// ignored like any unknown command and operation is always sequential.
// -----------------------------------------------------------------------------
module spi_sram_responder
    import spi_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_cs,
    input  logic          spi_sck,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          sel,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    logic sck_rise, sck_fall, cs_rise, cs_fall;

    spi_resp_sync u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .pin  (spi_cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_resp_sync u_sync_sck (
        .clk  (clk),
        .rst  (rst),
        .pin  (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // MOSI only needs a level; it is stable for several clk around SCK rise.
    logic [1:0] mosi_sync_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_sync_reg <= 2'b00;
        else     mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
    end

    spi_resp_state_t state_reg, state_next;
    logic [2:0]      bit_cnt_reg;
    logic [6:0]      shift_reg;     // seven bits received so far; the 8th is live MOSI
    logic            rd_cmd_reg;
    logic [7:0]      addr_hi_reg;
    logic [AW-1:0]   idx_reg;
    logic [7:0]      tx_reg;
    logic [7:0]      rd_data_reg;
    logic            fetch_reg;     // RAM read of idx_reg in flight this cycle
    logic            load_reg;      // rd_data_reg valid, move it to tx_reg
    logic            miso_reg;
    logic            sel_reg;
    logic            wr_strobe_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic [7:0]      wr_data_reg;
    logic [7:0]      mem [DEPTH];

    logic [7:0]  byte_next;
    logic [15:0] addr_full;
    logic        boundary;
    logic        mem_we;

    logic        mode_op;     // current transaction targets the mode register
    logic        byte_mode;
    logic [7:0]  mode_value;

    // A byte completes on the 8th synchronized rise; a coincident CS rise wins.
    assign byte_next = {shift_reg, mosi_sync_reg[1]};
    assign addr_full = {addr_hi_reg, byte_next};
    assign boundary  = sck_rise && !cs_rise && (bit_cnt_reg == 3'd7) && (state_reg != ST_IDLE);
    assign mem_we    = boundary && (state_reg == ST_DATA_WR) && !mode_op;

`ifdef SPI_RESP_MODE_REG_EN
    logic [7:0] mode_reg;
    logic       mode_op_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg    <= MODE_RESET;
            mode_op_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && cs_fall)
                mode_op_reg <= 1'b0;
            else if (boundary && state_reg == ST_CMD)
                mode_op_reg <= (byte_next == CMD_WRMR) || (byte_next == CMD_RDMR);
            if (boundary && state_reg == ST_DATA_WR && mode_op_reg)
                mode_reg <= byte_next;
        end
    end

    assign mode_op    = mode_op_reg;
    assign byte_mode  = (mode_reg[7:6] == MODE_BYTE);
    assign mode_value = mode_reg;
`else
    assign mode_op    = 1'b0;
    assign byte_mode  = 1'b0;
    assign mode_value = 8'h00;
`endif

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_IDLE) begin
            if (cs_fall) state_next = ST_CMD;
        end else if (cs_rise) begin
            state_next = ST_IDLE;
        end else if (boundary) begin
            case (state_reg)
                ST_CMD: begin
                    if (byte_next == CMD_READ || byte_next == CMD_WRITE)
                        state_next = ST_ADDR_HI;
`ifdef SPI_RESP_MODE_REG_EN
                    else if (byte_next == CMD_WRMR)
                        state_next = ST_DATA_WR;
                    else if (byte_next == CMD_RDMR)
                        state_next = ST_DATA_RD;
`endif
                    else
                        state_next = ST_IGNORE;
                end
                ST_ADDR_HI: state_next = ST_ADDR_LO;
                ST_ADDR_LO: state_next = rd_cmd_reg ? ST_DATA_RD : ST_DATA_WR;
                ST_DATA_WR: if (mode_op || byte_mode) state_next = ST_IGNORE;
                ST_DATA_RD: if (!mode_op && byte_mode) state_next = ST_IGNORE;
                default:    state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 7'd0;
            rd_cmd_reg    <= 1'b0;
            addr_hi_reg   <= 8'h00;
            idx_reg       <= '0;
            tx_reg        <= 8'h00;
            fetch_reg     <= 1'b0;
            load_reg      <= 1'b0;
            miso_reg      <= 1'b0;
            sel_reg       <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= 8'h00;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= (state_next != ST_IDLE);
            wr_strobe_reg <= 1'b0;
            fetch_reg     <= 1'b0;
            load_reg      <= 1'b0;

            if (state_reg == ST_IDLE) begin
                if (cs_fall) begin
                    bit_cnt_reg <= 3'd0;
                    shift_reg   <= 7'd0;
                end
            end else if (sck_rise && !cs_rise) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                shift_reg   <= byte_next[6:0];
            end

            if (boundary) begin
                case (state_reg)
                    ST_CMD: begin
                        rd_cmd_reg <= (byte_next == CMD_READ);
                        // Only RDMR enters DATA_RD straight from CMD.
                        if (state_next == ST_DATA_RD) tx_reg <= mode_value;
                    end
                    ST_ADDR_HI: addr_hi_reg <= byte_next;
                    ST_ADDR_LO: begin
                        idx_reg   <= AW'(addr_full);
                        fetch_reg <= rd_cmd_reg;
                    end
                    ST_DATA_WR: begin
                        if (!mode_op) begin
                            wr_strobe_reg <= 1'b1;
                            wr_addr_reg   <= idx_reg;
                            wr_data_reg   <= byte_next;
                            idx_reg       <= idx_reg + AW'(1);
                        end
                    end
                    ST_DATA_RD: begin
                        if (mode_op) tx_reg    <= mode_value;
                        else         fetch_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Registered RAM read: idx_reg is presented during the fetch cycle,
            // data lands in tx_reg one cycle later, well before the next SCK fall.
            if (fetch_reg) begin
                idx_reg  <= idx_reg + AW'(1);
                load_reg <= 1'b1;
            end
            if (load_reg) tx_reg <= rd_data_reg;

            if (state_next != ST_DATA_RD) begin
                miso_reg <= 1'b0;
            end else if (state_reg == ST_DATA_RD && sck_fall) begin
                miso_reg <= tx_reg[7];
                tx_reg   <= {tx_reg[6:0], 1'b0};
            end
        end
    end

    // Storage is not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_reg] <= byte_next;
        rd_data_reg <= mem[idx_reg];
    end

    assign spi_miso  = miso_reg;
    assign sel       = sel_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;

endmodule

// File: tb/tb_spi_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_sram_responder
// Drives SPI mode-0 transactions into spi_sram_responder (DEPTH=64) and checks
// read bytes and write strobes against a byte-array model via scoreboards.
// Build with SPI_RESP_MODE_REG_EN defined to also exercise the mode register.
// -----------------------------------------------------------------------------
module tb_spi_sram_responder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int H     = 6;   // SCK half period in clk

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_cs;
    logic          spi_sck;
    logic          spi_mosi;
    logic          spi_miso;
    logic          sel;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    spi_sram_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_cs    (spi_cs),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .sel       (sel),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          strobe_count  = 0;
    int          strobe_pushed = 0;
    int          cur_idx       = 0;
    logic [7:0]  model_mem [DEPTH];
    logic [7:0]  rd_exp_q [$];
    logic [13:0] wr_exp_q [$];   // {index, data}
    logic [13:0] wr_e;
    logic [7:0]  rx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx_o);
        rx_o = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            wait_clk(H);
            rx_o[i]  = spi_miso;
            spi_sck  = 1'b1;
            wait_clk(H);
            spi_sck  = 1'b0;
        end
    endtask

    task automatic spi_begin();
        spi_cs = 1'b0;
        wait_clk(H);
    endtask

    task automatic spi_end();
        wait_clk(H);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(H + 2);
    endtask

    task automatic spi_cmd_addr(input logic [7:0] cmd, input logic [15:0] addr);
        logic [7:0] dummy;
        spi_begin();
        spi_xfer(cmd, 8, dummy);
        spi_xfer(addr[15:8], 8, dummy);
        spi_xfer(addr[7:0], 8, dummy);
        cur_idx = int'(addr) % DEPTH;
    endtask

    task automatic spi_write_byte(input logic [7:0] d);
        logic [7:0] dummy;
        wr_exp_q.push_back({6'(cur_idx), d});
        strobe_pushed++;
        model_mem[cur_idx] = d;
        cur_idx = (cur_idx + 1) % DEPTH;
        spi_xfer(d, 8, dummy);
    endtask

    task automatic spi_read_byte(input string tag);
        logic [7:0] got;
        rd_exp_q.push_back(model_mem[cur_idx]);
        cur_idx = (cur_idx + 1) % DEPTH;
        spi_xfer(8'h00, 8, got);
        check_val(tag, got, rd_exp_q.pop_front());
    endtask

    // Write-strobe scoreboard
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            strobe_count++;
            if (wr_exp_q.size() == 0) begin
                check_val("wr_unexpected", 1, 0);
            end else begin
                wr_e = wr_exp_q.pop_front();
                check_val("wr_addr", 32'(wr_addr), 32'(wr_e[13:8]));
                check_val("wr_data", 32'(wr_data), 32'(wr_e[7:0]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        wait_clk(3);
        check_val("rst_sel", sel, 0);
        check_val("rst_miso", spi_miso, 0);
        check_val("rst_wr_strobe", wr_strobe, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        wait_clk(5);

        // Write 11..55 at 0x0010, read back
        spi_cmd_addr(8'h02, 16'h0010);
        check_val("sel_active", sel, 1);
        for (int i = 1; i <= 5; i++) spi_write_byte(8'(8'h11 * i));
        spi_end();
        check_val("sel_idle", sel, 0);
        spi_cmd_addr(8'h03, 16'h0010);
        for (int i = 0; i < 5; i++) spi_read_byte("rd_seq");
        spi_end();

        // Wrap at DEPTH-1
        spi_cmd_addr(8'h02, 16'h003E);
        spi_write_byte(8'hAA); spi_write_byte(8'hBB); spi_write_byte(8'hCC);
        spi_end();
        spi_cmd_addr(8'h03, 16'h003F);
        spi_read_byte("rd_wrap"); spi_read_byte("rd_wrap");
        spi_end();

        // Upper address bits alias
        spi_cmd_addr(8'h02, 16'h1205);
        spi_write_byte(8'h5A);
        spi_end();
        spi_cmd_addr(8'h03, 16'h0005);
        spi_read_byte("rd_alias");
        spi_end();

        // Unknown command: MISO stays 0, nothing written
        snap = strobe_count;
        spi_begin();
        spi_xfer(8'h9F, 8, rx);
        for (int i = 0; i < 4; i++) begin
            spi_xfer(8'(8'hA5 ^ i), 8, rx);
            check_val("ignore_miso", rx, 0);
        end
        spi_end();
        check_val("ignore_no_strobe", strobe_count, snap);
        spi_cmd_addr(8'h03, 16'h0010);
        spi_read_byte("rd_after_ignore"); spi_read_byte("rd_after_ignore");
        spi_end();

        // Partial write byte aborted by CS
        spi_cmd_addr(8'h02, 16'h0020);
        spi_write_byte(8'hAB);
        spi_end();
        snap = strobe_count;
        spi_cmd_addr(8'h02, 16'h0020);
        spi_xfer(8'hF0, 4, rx);
        spi_end();
        check_val("abort_no_strobe", strobe_count, snap);
        spi_cmd_addr(8'h03, 16'h0020);
        spi_read_byte("rd_after_abort");
        spi_end();

        // Reset in the middle of a read; BB bit7 (=1) is on MISO at reset time
        spi_cmd_addr(8'h03, 16'h003E);
        spi_read_byte("rd_pre_rst");
        wait_clk(H - 1);
        check_val("pre_rst_miso", spi_miso, 1);
        rst = 1'b1;
        wait_clk(1);
        check_val("mid_rst_sel", sel, 0);
        check_val("mid_rst_miso", spi_miso, 0);
        rst = 1'b0;
        wait_clk(2 * H);
        check_val("post_rst_sel_cs_low", sel, 0);
        spi_end();
        spi_cmd_addr(8'h03, 16'h003E);
        for (int i = 0; i < 3; i++) spi_read_byte("rd_post_rst");
        spi_end();

`ifdef SPI_RESP_MODE_REG_EN
        // Byte mode: only the first data byte is committed
        spi_begin(); spi_xfer(8'h01, 8, rx); spi_xfer(8'h00, 8, rx); spi_end();
        spi_cmd_addr(8'h02, 16'h0008);
        spi_write_byte(8'h01);
        spi_xfer(8'h02, 8, rx);
        spi_end();
        spi_cmd_addr(8'h03, 16'h0008);
        spi_read_byte("rd_byte_mode");
        spi_xfer(8'h00, 8, rx);
        check_val("byte_mode_rd2", rx, 0);
        spi_end();
        spi_begin(); spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h00, 8, rx); check_val("rdmr_00", rx, 8'h00);
        spi_end();
        spi_begin(); spi_xfer(8'h01, 8, rx); spi_xfer(8'h40, 8, rx); spi_end();
        spi_begin(); spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h00, 8, rx); check_val("rdmr_40", rx, 8'h40);
        spi_xfer(8'h00, 8, rx); check_val("rdmr_40_rep", rx, 8'h40);
        spi_end();
`endif

        wait_clk(20);
        check_val("wr_queue_empty", wr_exp_q.size(), 0);
        check_val("strobe_total", strobe_count, strobe_pushed);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
